// File: rtl/perf_pkg.sv
// Shared types and default parameter values for the performance counter bank.
// The halt-detector state encoding lives here so that the bank and any software-facing collateral use one definition.
package perf_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_ARMED  = 2'd1,
      ST_HALTED = 2'd2
   } halt_state_e;

   localparam int DEF_NUM_CH      = 8;
   localparam int DEF_CNT_W       = 32;
   localparam int DEF_SATURATE    = 0;
   localparam int DEF_HALT_REPEAT = 2;
   localparam int REP_W           = 4;
   localparam int SEL_W           = 5;

endpackage

// File: rtl/perf_counter.sv
// Single event counter with wrap-or-saturate behaviour and an optional sticky overflow flag.
// The overflow flag exists only when PERF_OVF_FLAG_EN is defined.
module perf_counter
   import perf_pkg::*;
#(
   parameter int CNT_W    = DEF_CNT_W,
   parameter int SATURATE = DEF_SATURATE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
`ifdef PERF_OVF_FLAG_EN
   output logic             ovf,
`endif
   output logic [CNT_W-1:0] value
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   function automatic logic [CNT_W-1:0] step_count(input logic [CNT_W-1:0] cur);
      if (&cur) begin
         return (SATURATE != 0) ? cur : '0;
      end
      return cur + ONE;
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         value <= '0;
      end else if (clr) begin
         value <= '0;
      end else if (inc) begin
         value <= step_count(value);
      end
   end

`ifdef PERF_OVF_FLAG_EN
   // The flag is raised by any increment attempted at all-ones, whether it wraps or holds.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovf <= 1'b0;
      end else if (clr) begin
         ovf <= 1'b0;
      end else if (inc && (&value)) begin
         ovf <= 1'b1;
      end
   end
`endif

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CH event counters with snapshot shadows, registered readback and a self-loop halt detector.
// Define PERF_OVF_FLAG_EN to build per-channel sticky overflow flags; otherwise ovf_any is tied low.
module perf_counter_bank
   import perf_pkg::*;
#(
   parameter int NUM_CH      = DEF_NUM_CH,
   parameter int CNT_W       = DEF_CNT_W,
   parameter int SATURATE    = DEF_SATURATE,
   parameter int HALT_REPEAT = DEF_HALT_REPEAT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] ev,
   input  logic              pause,
   input  logic              clear,
   input  logic              commit,
   input  logic [31:0]       commit_pc,
   input  logic [31:0]       commit_pc_next,
   input  logic              snap,
   input  logic              rd_en,
   input  logic [SEL_W-1:0]  rd_sel,
   output logic              rd_valid,
   output logic [CNT_W-1:0]  rd_data,
   output logic              halt,
   output logic              halted,
   output logic              ovf_any
);

   logic [CNT_W-1:0]  live   [NUM_CH];
   logic [CNT_W-1:0]  shadow [NUM_CH];
   logic [NUM_CH-1:0] inc_vec;
   logic [CNT_W-1:0]  rd_mux;

`ifdef PERF_OVF_FLAG_EN
   logic [NUM_CH-1:0] ovf_vec;
`endif

   assign inc_vec = ev & {NUM_CH{~pause}};

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      perf_counter #(
         .CNT_W    (CNT_W),
         .SATURATE (SATURATE)
      ) u_cnt (
         .clk   (clk),
         .rst   (rst),
         .inc   (inc_vec[i]),
         .clr   (clear),
`ifdef PERF_OVF_FLAG_EN
         .ovf   (ovf_vec[i]),
`endif
         .value (live[i])
      );
   end

`ifdef PERF_OVF_FLAG_EN
   assign ovf_any = |ovf_vec;
`else
   assign ovf_any = 1'b0;
`endif

   // Shadows capture pre-update live values and are deliberately untouched by clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            shadow[i] <= '0;
         end
      end else if (snap) begin
         for (int i = 0; i < NUM_CH; i++) begin
            shadow[i] <= live[i];
         end
      end
   end

   // A read coinciding with snap bypasses the shadow so it returns the value being captured.
   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (rd_sel == SEL_W'(i)) begin
            rd_mux = snap ? live[i] : shadow[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) begin
            rd_data <= rd_mux;
         end
      end
   end

   halt_state_e      state;
   logic [REP_W-1:0] rep;
   logic [REP_W-1:0] rep_nxt;
   logic             same_pc;
   logic             qual;

   assign rep_nxt = rep + REP_W'(1);
   assign same_pc = (commit_pc_next == commit_pc);
   assign qual    = commit & ~pause;
   assign halted  = (state == ST_HALTED);

   // rep is zero in RUN, so the shared path yields repeat=1 on the first self-loop commit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_RUN;
         rep   <= '0;
         halt  <= 1'b0;
      end else begin
         halt <= 1'b0;
         if (clear) begin
            state <= ST_RUN;
            rep   <= '0;
         end else if (qual) begin
            case (state)
               ST_RUN, ST_ARMED: begin
                  if (same_pc) begin
                     rep <= rep_nxt;
                     if (rep_nxt == REP_W'(HALT_REPEAT)) begin
                        state <= ST_HALTED;
                        halt  <= 1'b1;
                     end else begin
                        state <= ST_ARMED;
                     end
                  end else begin
                     state <= ST_RUN;
                     rep   <= '0;
                  end
               end
               default: begin
                  state <= state;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: a wrapping and a saturating instance share stimulus and are checked against a behavioural model.
module tb_perf_counter_bank;

   localparam int NCH  = 8;
   localparam int CW   = 8;
   localparam int HR   = 2;
   localparam int MAXV = (1 << CW) - 1;
`ifdef PERF_OVF_FLAG_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic [NCH-1:0] ev = '0;
   logic           pause = 1'b0;
   logic           clear = 1'b0;
   logic           commit = 1'b0;
   logic [31:0]    commit_pc = '0;
   logic [31:0]    commit_pc_next = '0;
   logic           snap = 1'b0;
   logic           rd_en = 1'b0;
   logic [4:0]     rd_sel = '0;

   logic           rd_valid_w, rd_valid_s, halt_w, halt_s, halted_w, halted_s, ovf_any_w, ovf_any_s;
   logic [CW-1:0]  rd_data_w, rd_data_s;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   perf_counter_bank #(.NUM_CH(NCH), .CNT_W(CW), .SATURATE(0), .HALT_REPEAT(HR)) dut_w (
      .clk(clk), .rst(rst), .ev(ev), .pause(pause), .clear(clear), .commit(commit),
      .commit_pc(commit_pc), .commit_pc_next(commit_pc_next), .snap(snap), .rd_en(rd_en),
      .rd_sel(rd_sel), .rd_valid(rd_valid_w), .rd_data(rd_data_w), .halt(halt_w),
      .halted(halted_w), .ovf_any(ovf_any_w));

   perf_counter_bank #(.NUM_CH(NCH), .CNT_W(CW), .SATURATE(1), .HALT_REPEAT(HR)) dut_s (
      .clk(clk), .rst(rst), .ev(ev), .pause(pause), .clear(clear), .commit(commit),
      .commit_pc(commit_pc), .commit_pc_next(commit_pc_next), .snap(snap), .rd_en(rd_en),
      .rd_sel(rd_sel), .rd_valid(rd_valid_s), .rd_data(rd_data_s), .halt(halt_s),
      .halted(halted_s), .ovf_any(ovf_any_s));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: index 0 = wrapping instance, index 1 = saturating instance.
   int mc [2][NCH];
   int ms [2][NCH];
   bit mo [2][NCH];
   bit m_rdv = 1'b0;
   int m_rdd [2];
   bit m_halt = 1'b0;
   bit m_halted = 1'b0;
   int m_rep = 0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int d = 0; d < 2; d++) begin
            m_rdd[d] = 0;
            for (int i = 0; i < NCH; i++) begin
               mc[d][i] = 0; ms[d][i] = 0; mo[d][i] = 1'b0;
            end
         end
         m_rdv = 1'b0; m_halt = 1'b0; m_halted = 1'b0; m_rep = 0;
      end else begin
         for (int d = 0; d < 2; d++) begin
            if (snap) begin
               for (int i = 0; i < NCH; i++) ms[d][i] = mc[d][i];
            end
            if (rd_en) begin
               if (rd_sel < NCH) m_rdd[d] = ms[d][rd_sel];
               else m_rdd[d] = 0;
            end
            for (int i = 0; i < NCH; i++) begin
               if (clear) begin
                  mc[d][i] = 0; mo[d][i] = 1'b0;
               end else if (ev[i] && !pause) begin
                  if (mc[d][i] == MAXV) begin
                     mo[d][i] = 1'b1;
                     mc[d][i] = (d == 0) ? 0 : MAXV;
                  end else begin
                     mc[d][i] = mc[d][i] + 1;
                  end
               end
            end
         end
         m_rdv = rd_en;
         m_halt = 1'b0;
         if (clear) begin
            m_halted = 1'b0; m_rep = 0;
         end else if (!m_halted && commit && !pause) begin
            if (commit_pc == commit_pc_next) begin
               m_rep = m_rep + 1;
               if (m_rep >= HR) begin
                  m_halted = 1'b1; m_halt = 1'b1;
               end
            end else begin
               m_rep = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst === 1'b1) begin
         bit ow, os;
         ow = 1'b0; os = 1'b0;
         for (int i = 0; i < NCH; i++) begin
            ow |= mo[0][i]; os |= mo[1][i];
         end
         check("rd_valid_w", rd_valid_w, m_rdv);
         check("rd_valid_s", rd_valid_s, m_rdv);
         if (m_rdv) begin
            check("rd_data_w", rd_data_w, m_rdd[0]);
            check("rd_data_s", rd_data_s, m_rdd[1]);
         end
         check("halt_w", halt_w, m_halt);
         check("halt_s", halt_s, m_halt);
         check("halted_w", halted_w, m_halted);
         check("halted_s", halted_s, m_halted);
         check("ovf_any_w", ovf_any_w, OVF_EN & ow);
         check("ovf_any_s", ovf_any_s, OVF_EN & os);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic cycles(input int n);
      for (int k = 0; k < n; k++) cyc();
   endtask

   task automatic read_chk(input int sel, input bit with_snap, input int ew, input int es, input string nm);
      rd_en = 1'b1; rd_sel = 5'(sel); snap = with_snap;
      cyc();
      rd_en = 1'b0; snap = 1'b0;
      check({nm, "_valid"}, rd_valid_w, 1'b1);
      check({nm, "_w"}, rd_data_w, ew);
      check({nm, "_s"}, rd_data_s, es);
   endtask

   task automatic all_zero(input string nm);
      check({nm, "_rd_valid"}, {rd_valid_w, rd_valid_s}, 2'b00);
      check({nm, "_rd_data"}, {rd_data_w, rd_data_s}, 16'h0);
      check({nm, "_halt"}, {halt_w, halt_s}, 2'b00);
      check({nm, "_halted"}, {halted_w, halted_s}, 2'b00);
      check({nm, "_ovf_any"}, {ovf_any_w, ovf_any_s}, 2'b00);
   endtask

   task automatic do_commit(input logic [31:0] pc, input logic [31:0] nxt);
      commit = 1'b1; commit_pc = pc; commit_pc_next = nxt;
      cyc();
      commit = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #2;
      all_zero("reset");
      rst = 1'b1;
      cyc();

      // 256 pulses: wrap to 0 vs. hold at 255, both flag overflow.
      ev = 8'h01;
      cycles(256);
      ev = '0;
      check("ovf_after_256_w", ovf_any_w, OVF_EN);
      check("ovf_after_256_s", ovf_any_s, OVF_EN);
      read_chk(0, 1'b1, 0, 255, "wrap256");

      clear = 1'b1; cyc(); clear = 1'b0;
      check("ovf_cleared", {ovf_any_w, ovf_any_s}, 2'b00);

      // 300 pulses then 10 paused pulses.
      ev = 8'h08;
      cycles(300);
      pause = 1'b1;
      cycles(10);
      pause = 1'b0; ev = '0;
      read_chk(3, 1'b1, 44, 255, "ch3_300");

      // ev, clear and snap together with counter 1 at 5.
      clear = 1'b1; cyc(); clear = 1'b0;
      ev = 8'h02;
      cycles(5);
      clear = 1'b1; snap = 1'b1;
      cyc();
      clear = 1'b0; snap = 1'b0; ev = '0;
      read_chk(1, 1'b0, 5, 5, "shadow_keeps");
      read_chk(1, 1'b1, 0, 0, "cleared_live");
      ev = 8'h04;
      cycles(3);
      ev = '0;
      read_chk(2, 1'b1, 3, 3, "snap_bypass");

      read_chk(31, 1'b0, 0, 0, "sel_oob");

      // Halt detector.
      clear = 1'b1; cyc(); clear = 1'b0;
      pause = 1'b1;
      do_commit(32'h60, 32'h60);
      do_commit(32'h60, 32'h60);
      pause = 1'b0;
      check("paused_no_halt", {halted_w, halted_s}, 2'b00);
      do_commit(32'h60, 32'h60);
      do_commit(32'h64, 32'h68);
      do_commit(32'h60, 32'h60);
      check("interrupted_no_halt", {halt_w, halted_w}, 2'b00);
      cyc();
      do_commit(32'h60, 32'h60);
      check("halt_pulse", {halt_w, halt_s}, 2'b11);
      check("halted_level", {halted_w, halted_s}, 2'b11);
      cyc();
      check("halt_one_shot", {halt_w, halt_s}, 2'b00);
      check("halted_holds", {halted_w, halted_s}, 2'b11);
      do_commit(32'h60, 32'h60);
      do_commit(32'h60, 32'h60);

      // Async reset mid-cycle with rd_valid, halted and overflow all active.
      ev = 8'h01;
      cycles(256);
      ev = '0;
      read_chk(0, 1'b1, 0, 255, "pre_reset");
      check("pre_reset_halted", {halted_w, halted_s}, 2'b11);
      #2;
      rst = 1'b0;
      #1;
      all_zero("async_reset");
      #2;
      rst = 1'b1;
      ev = 8'h01;
      cycles(2);
      ev = '0;
      read_chk(0, 1'b1, 2, 2, "resume");
      cycles(3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
